vram_access_ctrl: RTL and testbench
===================================

// Module: vram_access_ctrl
// PURPOSE
//  Upstream stage of the HuC6270 VRAM: sole driver of the VRAM address, write-enable and write-data pins.
//  Arbitrates three requesters for the single-port VRAM: display fetch (background/sprite), CPU write (MAWR/VWR) and CPU read prefetch (MARR/VRR).
//  Owns the MAWR/MARR auto-increment pointers and the VRR read latch.
//  Routes VRAM read data (1-cycle synchronous BRAM latency) back to the requester that issued the read.
// PARAMETERS
//  AW        16  VDC word-address width (MAWR/MARR/fetch_addr)
//  RAM_AW    15  physical VRAM address width (32K words); addresses >= 2**RAM_AW are unmapped
//  DW        16  VRAM word width
// PORTS
//  clock        in   1    system clock
//  reset        in   1    synchronous, active-high reset
//  mawr_wr      in   1    load MAWR from addr_in
//  marr_wr      in   1    load MARR from addr_in; schedule read prefetch
//  addr_in      in   AW   address for mawr_wr/marr_wr
//  inc_sel      in   2    auto-increment: 0:+1 1:+32 2:+64 3:+128
//  vwr_wr       in   1    CPU write strobe; captures {MAWR, vwr_data}
//  vwr_data     in   DW   CPU write data
//  vrr_rd       in   1    CPU consumed VRR; advance MARR, schedule prefetch
//  vrr_data     out  DW   read latch (VRR)
//  cpu_busy     out  1    CPU op outstanding; strobes while high are ignored
//  fetch_req    in   1    display fetch request (highest priority, always granted)
//  fetch_addr   in   AW   display fetch address
//  fetch_data   out  DW   fetch read data
//  fetch_valid  out  1    fetch_data valid; exactly 1 cycle after the fetch_req cycle
//  vram_ma      out  RAM_AW  VRAM address
//  vram_we      out  1    VRAM write enable
//  vram_wdata   out  DW   VRAM write data
//  vram_rdata   in   DW   VRAM read data (valid 1 cycle after address)
// BEHAVIOUR
//  Reset: MAWR=MARR=0, vrr_data=0, wr_pend=rd_pend=0, in-flight tag=NONE; vram_we=0, vram_ma=0, vram_wdata=0, fetch_valid=0, fetch_data=0, cpu_busy=0.
//  Reset mid-op: pending/in-flight ops dropped; no VRAM write in reset cycle or the cycle after.
//  Pointer update (per cycle): marr_wr overrides vrr_rd; mawr_wr overrides the vwr_wr increment. All pointer sums wrap mod 2**AW.
//  vwr_wr with !cpu_busy: wr_addr<=MAWR (old value), wr_data<=vwr_data, wr_pend<=1, MAWR<=MAWR+inc.
//  marr_wr: MARR<=addr_in, rd_pend<=1 (accepted even if busy; restarts the read).
//  vrr_rd with !cpu_busy: MARR<=MARR+inc, rd_pend<=1.
//  Grant (combinational, 1 op/cycle): fetch_req > wr_pend > rd_pend. Losers hold; no starvation guarantee beyond fetch gaps.
//  WRITE grant: vram_we=1, vram_ma=wr_addr, wr_pend<=0. Write to unmapped address: vram_we=0, still retires.
//  READ grant (fetch or CPU): vram_we=0, vram_ma=addr; tag<=FETCH|CPU; CPU read also clears rd_pend.
//  Return cycle: tag FETCH -> fetch_data<=vram_rdata, fetch_valid=1; tag CPU -> vrr_data<=vram_rdata.
//  Unmapped read (addr bit >= RAM_AW set): returned data forced to 0x0000.
//  CPU read result is discarded if rd_pend was re-set (marr_wr) during its flight; vrr_data updates only from the newest read.
//  cpu_busy = wr_pend | rd_pend | (tag==CPU).
//  Simultaneous vwr_wr and vrr_rd when idle: both accepted; write retires before read.
//  FSM (CPU side): IDLE -> WR_PEND (vwr_wr) -> IDLE on grant; IDLE -> RD_PEND (marr_wr/vrr_rd) -> RD_WAIT on grant -> IDLE on return.
// STRUCTURE
//  vdc_pkg: inc_step_t enum + inc_amount() function, vram_tag_t {NONE,FETCH,CPU}, AW/RAM_AW/DW constants.
//  Sub-module vram_arb: 3-way fixed-priority grant, combinational.
//  Top: pointers, pending regs, tag pipe, output muxing/registers.
// TESTING
//  mawr_wr 0x0100, inc_sel=1, vwr_wr 0xBEEF then 0xCAFE -> writes at 0x0100 and 0x0120; MAWR=0x0140.
//  marr_wr 0x0100 -> cpu_busy ~2 cycles, then vrr_data=0xBEEF; vrr_rd -> vrr_data=0xCAFE.
//  fetch_req held 10 cycles during pending CPU write -> fetch_valid every cycle, write issues on first idle cycle.
//  MAWR=0xFFFF, inc_sel=0, vwr_wr -> no vram_we (unmapped); MAWR wraps to 0x0000.
//  marr_wr twice back-to-back (0x0010, 0x0020) -> vrr_data ends at mem[0x0020], never shows mem[0x0010] last.
//  reset asserted with wr_pend=1 -> vram_we stays 0; all outputs at reset values next cycle.

Source files
------------

// File: rtl/vdc_pkg.sv
// Shared VDC VRAM-port types: pointer increment steps, read-return tags, arbiter grants.
// No logic; widths here are the defaults used by vram_access_ctrl.
package vdc_pkg;

   localparam int AW     = 16;
   localparam int RAM_AW = 15;
   localparam int DW     = 16;

   typedef enum logic [1:0] {
      INC_1   = 2'd0,
      INC_32  = 2'd1,
      INC_64  = 2'd2,
      INC_128 = 2'd3
   } inc_step_t;

   typedef enum logic [1:0] {
      TAG_NONE  = 2'd0,
      TAG_FETCH = 2'd1,
      TAG_CPU   = 2'd2
   } vram_tag_t;

   typedef enum logic [1:0] {
      GNT_NONE  = 2'd0,
      GNT_FETCH = 2'd1,
      GNT_WR    = 2'd2,
      GNT_RD    = 2'd3
   } vram_gnt_t;

   // Narrow return keeps the helper independent of the pointer width.
   function automatic logic [7:0] inc_amount(input inc_step_t step);
      case (step)
         INC_32:  return 8'd32;
         INC_64:  return 8'd64;
         INC_128: return 8'd128;
         default: return 8'd1;
      endcase
   endfunction

endpackage

// File: rtl/vram_arb.sv
// Fixed-priority VRAM port arbiter: display fetch > CPU write > CPU read, one grant per cycle.
// Combinational, zero latency; losing requesters simply stay pending.
module vram_arb
   import vdc_pkg::*;
(
   input  logic      fetch_req,
   input  logic      wr_req,
   input  logic      rd_req,
   output vram_gnt_t gnt
);

   always_comb begin
      gnt = GNT_NONE;
      if (fetch_req) begin
         gnt = GNT_FETCH;
      end else if (wr_req) begin
         gnt = GNT_WR;
      end else if (rd_req) begin
         gnt = GNT_RD;
      end
   end

endmodule

// File: rtl/vram_access_ctrl.sv
// HuC6270 VRAM port owner: MAWR/MARR pointers, VRR latch, fetch/CPU arbitration, read-data return routing.
// Address issued in the grant cycle, data returned 1 cycle later; CPU strobes ignored while cpu_busy.
module vram_access_ctrl #(
   parameter int AW     = vdc_pkg::AW,
   parameter int RAM_AW = vdc_pkg::RAM_AW,
   parameter int DW     = vdc_pkg::DW
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              mawr_wr,
   input  logic              marr_wr,
   input  logic [AW-1:0]     addr_in,
   input  logic [1:0]        inc_sel,
   input  logic              vwr_wr,
   input  logic [DW-1:0]     vwr_data,
   input  logic              vrr_rd,
   output logic [DW-1:0]     vrr_data,
   output logic              cpu_busy,
   input  logic              fetch_req,
   input  logic [AW-1:0]     fetch_addr,
   output logic [DW-1:0]     fetch_data,
   output logic              fetch_valid,
   output logic [RAM_AW-1:0] vram_ma,
   output logic              vram_we,
   output logic [DW-1:0]     vram_wdata,
   input  logic [DW-1:0]     vram_rdata
);

   import vdc_pkg::*;

   logic [AW-1:0] mawr;
   logic [AW-1:0] marr;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_dat;
   logic          wr_pend;
   logic          rd_pend;
   logic [DW-1:0] vrr_q;
   logic [DW-1:0] fetch_hold_dat;
   vram_tag_t     tag;
   logic          ret_unmapped;

   logic [AW-1:0] inc;
   logic          vwr_ok;
   logic          vrr_ok;
   vram_gnt_t     gnt;
   logic [AW-1:0] gnt_addr;
   logic          gnt_mapped;
   logic [DW-1:0] ret_dat;

   assign inc    = AW'(inc_amount(inc_step_t'(inc_sel)));
   assign vwr_ok = vwr_wr & ~cpu_busy;
   assign vrr_ok = vrr_rd & ~cpu_busy;

   // Requests are masked during reset so a pending write cannot reach the pins in the reset cycle.
   vram_arb u_arb (
      .fetch_req (fetch_req & ~reset),
      .wr_req    (wr_pend & ~reset),
      .rd_req    (rd_pend & ~reset),
      .gnt       (gnt)
   );

   always_comb begin
      gnt_addr = '0;
      case (gnt)
         GNT_FETCH: gnt_addr = fetch_addr;
         GNT_WR:    gnt_addr = wr_addr;
         GNT_RD:    gnt_addr = marr;
         default:   gnt_addr = '0;
      endcase
   end

   assign gnt_mapped = ~|gnt_addr[AW-1:RAM_AW];
   assign vram_ma    = gnt_addr[RAM_AW-1:0];
   assign vram_we    = (gnt == GNT_WR) & gnt_mapped;
   assign vram_wdata = (gnt == GNT_WR) ? wr_dat : '0;

   assign ret_dat     = ret_unmapped ? '0 : vram_rdata;
   assign fetch_valid = (tag == TAG_FETCH) & ~reset;
   assign fetch_data  = fetch_valid ? ret_dat : fetch_hold_dat;
   assign vrr_data    = vrr_q;
   assign cpu_busy    = wr_pend | rd_pend | (tag == TAG_CPU);

   always_ff @(posedge clock) begin
      if (reset) begin
         mawr           <= '0;
         marr           <= '0;
         wr_addr        <= '0;
         wr_dat         <= '0;
         wr_pend        <= 1'b0;
         rd_pend        <= 1'b0;
         vrr_q          <= '0;
         fetch_hold_dat <= '0;
         tag            <= TAG_NONE;
         ret_unmapped   <= 1'b0;
      end else begin
         if (mawr_wr) begin
            mawr <= addr_in;
         end else if (vwr_ok) begin
            mawr <= mawr + inc;
         end

         if (vwr_ok) begin
            wr_addr <= mawr;
            wr_dat  <= vwr_data;
            wr_pend <= 1'b1;
         end else if (gnt == GNT_WR) begin
            wr_pend <= 1'b0;
         end

         // A MARR load restarts the prefetch even when a read is already in flight.
         if (marr_wr) begin
            marr    <= addr_in;
            rd_pend <= 1'b1;
         end else if (vrr_ok) begin
            marr    <= marr + inc;
            rd_pend <= 1'b1;
         end else if (gnt == GNT_RD) begin
            rd_pend <= 1'b0;
         end

         case (gnt)
            GNT_FETCH: tag <= TAG_FETCH;
            GNT_RD:    tag <= TAG_CPU;
            default:   tag <= TAG_NONE;
         endcase
         ret_unmapped <= ~gnt_mapped;

         if (tag == TAG_FETCH) begin
            fetch_hold_dat <= ret_dat;
         end
         // rd_pend still set on return means a newer MARR load superseded this read.
         if ((tag == TAG_CPU) && !rd_pend) begin
            vrr_q <= ret_dat;
         end
      end
   end

endmodule

// File: tb/tb_vram_access_ctrl.sv
// Directed bench for vram_access_ctrl: per-cycle vector table plus hand sequences for
// fetch starvation, unmapped write/wrap, superseded prefetch and reset during a pending write.
module tb_vram_access_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        mawr_wr, marr_wr, vwr_wr, vrr_rd, fetch_req;
   logic [15:0] addr_in, vwr_data, fetch_addr;
   logic [1:0]  inc_sel;
   logic [15:0] vrr_data, fetch_data, vram_wdata;
   logic [15:0] vram_rdata = 16'h0000;
   logic        cpu_busy, fetch_valid, vram_we;
   logic [14:0] vram_ma;

   always #5 clock = ~clock;

   vram_access_ctrl dut (
      .clock       (clock),
      .reset       (reset),
      .mawr_wr     (mawr_wr),
      .marr_wr     (marr_wr),
      .addr_in     (addr_in),
      .inc_sel     (inc_sel),
      .vwr_wr      (vwr_wr),
      .vwr_data    (vwr_data),
      .vrr_rd      (vrr_rd),
      .vrr_data    (vrr_data),
      .cpu_busy    (cpu_busy),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_data  (fetch_data),
      .fetch_valid (fetch_valid),
      .vram_ma     (vram_ma),
      .vram_we     (vram_we),
      .vram_wdata  (vram_wdata),
      .vram_rdata  (vram_rdata)
   );

   // Synchronous single-port VRAM, preloaded with ~address.
   logic [15:0] mem [0:32767];
   always @(posedge clock) begin
      if (vram_we) mem[vram_ma] <= vram_wdata;
      vram_rdata <= mem[vram_ma];
   end

   function automatic logic [15:0] pat(input logic [15:0] a);
      return ~a;
   endfunction

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic idle();
      mawr_wr   = 1'b0;
      marr_wr   = 1'b0;
      vwr_wr    = 1'b0;
      vrr_rd    = 1'b0;
      fetch_req = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic smp();
      @(negedge clock);
   endtask

   localparam logic [1:0] A_N = 2'd0, A_W = 2'd1, A_R = 2'd2;

   // ctl = {mawr_wr, marr_wr, vwr_wr, vrr_rd, fetch_req}; addr drives both addr_in and fetch_addr.
   typedef struct {
      logic [4:0]  ctl;
      logic [15:0] addr;
      logic [1:0]  inc;
      logic [15:0] dat;
      logic [1:0]  act;
      logic [14:0] ma;
      logic [15:0] wd;
      logic        busy;
      logic        fv;
      logic [15:0] fd;
      logic [15:0] vrr;
   } vec_t;

   localparam int NV = 27;
   vec_t tbl [NV];

   initial begin
      tbl[0]  = '{5'b10000, 16'h0100, 2'd1, 16'h0000, A_N, 15'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
      tbl[1]  = '{5'b00100, 16'h0000, 2'd1, 16'hBEEF, A_N, 15'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
      tbl[2]  = '{5'b00000, 16'h0000, 2'd1, 16'h0000, A_W, 15'h0100, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 16'h0000};
      tbl[3]  = '{5'b00100, 16'h0000, 2'd1, 16'hCAFE, A_N, 15'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
      tbl[4]  = '{5'b00000, 16'h0000, 2'd1, 16'h0000, A_W, 15'h0120, 16'hCAFE, 1'b1, 1'b0, 16'h0000, 16'h0000};
      tbl[5]  = '{5'b01000, 16'h0100, 2'd1, 16'h0000, A_N, 15'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
      tbl[6]  = '{5'b00000, 16'h0000, 2'd1, 16'h0000, A_R, 15'h0100, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000};
      tbl[7]  = '{5'b00000, 16'h0000, 2'd1, 16'h0000, A_N, 15'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000};
      tbl[8]  = '{5'b00010, 16'h0000, 2'd1, 16'h0000, A_N, 15'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hBEEF};
      tbl[9]  = '{5'b00000, 16'h0000, 2'd1, 16'h0000, A_R, 15'h0120, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'hBEEF};
      tbl[10] = '{5'b00000, 16'h0000, 2'd1, 16'h0000, A_N, 15'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'hBEEF};
      tbl[11] = '{5'b00000, 16'h0000, 2'd1, 16'h0000, A_N, 15'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hCAFE};
      tbl[12] = '{5'b00100, 16'h0000, 2'd1, 16'h1234, A_N, 15'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hCAFE};
      tbl[13] = '{5'b00000, 16'h0000, 2'd1, 16'h0000, A_W, 15'h0140, 16'h1234, 1'b1, 1'b0, 16'h0000, 16'hCAFE};
      tbl[14] = '{5'b00001, 16'h0120, 2'd1, 16'h0000, A_R, 15'h0120, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hCAFE};
      tbl[15] = '{5'b00000, 16'h0000, 2'd1, 16'h0000, A_N, 15'h0000, 16'h0000, 1'b0, 1'b1, 16'hCAFE, 16'hCAFE};
      tbl[16] = '{5'b00001, 16'h8005, 2'd1, 16'h0000, A_R, 15'h0005, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hCAFE};
      tbl[17] = '{5'b00000, 16'h0000, 2'd1, 16'h0000, A_N, 15'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'hCAFE};
      tbl[18] = '{5'b10000, 16'h0201, 2'd0, 16'h0000, A_N, 15'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hCAFE};
      tbl[19] = '{5'b01000, 16'h0200, 2'd0, 16'h0000, A_N, 15'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hCAFE};
      tbl[20] = '{5'b00000, 16'h0000, 2'd0, 16'h0000, A_R, 15'h0200, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'hCAFE};
      tbl[21] = '{5'b00000, 16'h0000, 2'd0, 16'h0000, A_N, 15'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'hCAFE};
      tbl[22] = '{5'b00110, 16'h0000, 2'd0, 16'h7777, A_N, 15'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hFDFF};
      tbl[23] = '{5'b00000, 16'h0000, 2'd0, 16'h0000, A_W, 15'h0201, 16'h7777, 1'b1, 1'b0, 16'h0000, 16'hFDFF};
      tbl[24] = '{5'b00000, 16'h0000, 2'd0, 16'h0000, A_R, 15'h0201, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'hFDFF};
      tbl[25] = '{5'b00000, 16'h0000, 2'd0, 16'h0000, A_N, 15'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'hFDFF};
      tbl[26] = '{5'b00000, 16'h0000, 2'd0, 16'h0000, A_N, 15'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h7777};

      for (int i = 0; i < 32768; i++) mem[i] = ~16'(i);

      reset      = 1'b1;
      idle();
      addr_in    = 16'h0000;
      fetch_addr = 16'h0000;
      vwr_data   = 16'h0000;
      inc_sel    = 2'd0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      smp();
      chk("rst_we",    32'(vram_we),     32'h0);
      chk("rst_ma",    32'(vram_ma),     32'h0);
      chk("rst_wdata", 32'(vram_wdata),  32'h0);
      chk("rst_fvld",  32'(fetch_valid), 32'h0);
      chk("rst_fdata", 32'(fetch_data),  32'h0);
      chk("rst_busy",  32'(cpu_busy),    32'h0);
      chk("rst_vrr",   32'(vrr_data),    32'h0);

      for (int i = 0; i < NV; i++) begin
         cyc();
         {mawr_wr, marr_wr, vwr_wr, vrr_rd, fetch_req} = tbl[i].ctl;
         addr_in    = tbl[i].addr;
         fetch_addr = tbl[i].addr;
         inc_sel    = tbl[i].inc;
         vwr_data   = tbl[i].dat;
         smp();
         chk($sformatf("row%0d_we", i), 32'(vram_we), 32'(tbl[i].act == A_W));
         if (tbl[i].act != A_N) chk($sformatf("row%0d_ma", i), 32'(vram_ma), 32'(tbl[i].ma));
         if (tbl[i].act == A_W) chk($sformatf("row%0d_wdata", i), 32'(vram_wdata), 32'(tbl[i].wd));
         chk($sformatf("row%0d_busy", i), 32'(cpu_busy), 32'(tbl[i].busy));
         chk($sformatf("row%0d_fvld", i), 32'(fetch_valid), 32'(tbl[i].fv));
         if (tbl[i].fv) chk($sformatf("row%0d_fdata", i), 32'(fetch_data), 32'(tbl[i].fd));
         chk($sformatf("row%0d_vrr", i), 32'(vrr_data), 32'(tbl[i].vrr));
      end

      // Fetch held for 10 cycles starves a pending CPU write until the first free cycle.
      cyc(); idle(); mawr_wr = 1'b1; addr_in = 16'h0400; inc_sel = 2'd0; smp();
      cyc(); idle(); vwr_wr = 1'b1; vwr_data = 16'hA5A5; smp();
      chk("fh_accept_busy", 32'(cpu_busy), 32'h0);
      for (int i = 0; i < 10; i++) begin
         cyc(); idle(); fetch_req = 1'b1; fetch_addr = 16'h0300 + 16'(i); smp();
         chk($sformatf("fh%0d_we", i), 32'(vram_we), 32'h0);
         chk($sformatf("fh%0d_ma", i), 32'(vram_ma), 32'h0300 + 32'(i));
         if (i > 0) begin
            chk($sformatf("fh%0d_fvld", i), 32'(fetch_valid), 32'h1);
            chk($sformatf("fh%0d_fdata", i), 32'(fetch_data), 32'(pat(16'h0300 + 16'(i - 1))));
         end
      end
      cyc(); idle(); smp();
      chk("fh_last_fvld",  32'(fetch_valid), 32'h1);
      chk("fh_last_fdata", 32'(fetch_data),  32'(pat(16'h0309)));
      chk("fh_wr_we",      32'(vram_we),     32'h1);
      chk("fh_wr_ma",      32'(vram_ma),     32'h0400);
      chk("fh_wr_wdata",   32'(vram_wdata),  32'hA5A5);

      // Write to an unmapped address retires without vram_we; MAWR wraps to 0.
      cyc(); idle(); mawr_wr = 1'b1; addr_in = 16'hFFFF; inc_sel = 2'd0; smp();
      cyc(); idle(); vwr_wr = 1'b1; vwr_data = 16'h1111; smp();
      chk("um_accept_busy", 32'(cpu_busy), 32'h0);
      cyc(); idle(); smp();
      chk("um_we",   32'(vram_we),  32'h0);
      chk("um_busy", 32'(cpu_busy), 32'h1);
      cyc(); idle(); vwr_wr = 1'b1; vwr_data = 16'h2222; smp();
      chk("um_retired_busy", 32'(cpu_busy), 32'h0);
      cyc(); idle(); smp();
      chk("wrap_we",    32'(vram_we),    32'h1);
      chk("wrap_ma",    32'(vram_ma),    32'h0000);
      chk("wrap_wdata", 32'(vram_wdata), 32'h2222);

      // Back-to-back MARR loads: only the second read may land in VRR.
      begin
         logic seen_stale = 1'b0;
         logic done       = 1'b0;
         cyc(); idle(); marr_wr = 1'b1; addr_in = 16'h0010; smp();
         cyc(); idle(); marr_wr = 1'b1; addr_in = 16'h0020; smp();
         chk("b2b_first_ma", 32'(vram_ma),  32'h0010);
         chk("b2b_busy",     32'(cpu_busy), 32'h1);
         for (int k = 0; k < 20; k++) begin
            cyc(); idle(); smp();
            if (vrr_data == pat(16'h0010)) seen_stale = 1'b1;
            if (!cpu_busy) begin
               done = 1'b1;
               break;
            end
         end
         chk("b2b_done",  32'(done),       32'h1);
         chk("b2b_stale", 32'(seen_stale), 32'h0);
         chk("b2b_vrr",   32'(vrr_data),   32'(pat(16'h0020)));
      end

      // Reset while a write is pending: no write in the reset cycle or after.
      cyc(); idle(); vwr_wr = 1'b1; vwr_data = 16'h3333; smp();
      chk("rm_accept_busy", 32'(cpu_busy), 32'h0);
      cyc(); idle(); reset = 1'b1; smp();
      chk("rm_reset_we", 32'(vram_we), 32'h0);
      cyc(); reset = 1'b0; smp();
      chk("rm_we",    32'(vram_we),     32'h0);
      chk("rm_ma",    32'(vram_ma),     32'h0);
      chk("rm_wdata", 32'(vram_wdata),  32'h0);
      chk("rm_fvld",  32'(fetch_valid), 32'h0);
      chk("rm_fdata", 32'(fetch_data),  32'h0);
      chk("rm_busy",  32'(cpu_busy),    32'h0);
      chk("rm_vrr",   32'(vrr_data),    32'h0);
      cyc(); smp();
      chk("rm_after_we",   32'(vram_we),  32'h0);
      chk("rm_after_busy", 32'(cpu_busy), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
